// File: rtl/data_mem_responder_pkg.sv
// Shared types and defaults for the data memory responder and its wait counter.
package data_mem_responder_pkg;

  localparam int DMR_DEPTH_DEFAULT = 256;
  localparam int DMR_WAIT_DEFAULT  = 2;
  localparam int CNT_W             = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmr_state_e;

  // A request is rejected when misaligned, beyond the array, or both directions at once.
  function automatic logic req_bad(input logic [31:0] addr, input logic rd, input logic wr,
                                   input int aw);
    logic [31:0] hi;
    hi = addr >> (aw + 2);
    return (rd & wr) | (addr[1:0] != 2'b00) | (hi != 32'd0);
  endfunction

endpackage

// File: rtl/data_mem_responder_wait_counter.sv
// Loadable down-counter that paces the wait states of one memory access.
module wait_counter
  import data_mem_responder_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] loadVal,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  logic [CNT_W-1:0] r_count;

  // Count register: load wins over decrement, saturates at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= {CNT_W{1'b0}};
    end else if (load) begin
      r_count <= loadVal;
    end else if (en && (r_count != {CNT_W{1'b0}})) begin
      r_count <= r_count - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign count = r_count;
  assign last  = (r_count == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder: single-port word store behind an IDLE/WAIT/RESP FSM
// that answers MEM-stage load/store requests with a one-cycle ready pulse.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH       = DMR_DEPTH_DEFAULT,
  parameter int WAIT_CYCLES = DMR_WAIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  output logic        stall,
  output logic        err
);

  localparam int               AW       = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] WAIT_VAL = CNT_W'(WAIT_CYCLES);
  localparam bit               NO_WAIT  = (WAIT_CYCLES == 0);

  dmr_state_e       r_state;
  dmr_state_e       w_next_state;
  logic [AW-1:0]    r_idx;
  logic [31:0]      r_wdata;
  logic             r_write;
  logic             r_bad;
  logic [31:0]      r_rdata;
  logic             r_ready;
  logic             r_err;
  logic [31:0]      r_mem [DEPTH];

  logic             w_req;
  logic             w_start;
  logic             w_to_resp;
  logic             w_cnt_en;
  logic             w_cnt_last;
  logic             w_commit;
  logic             w_acc_bad;
  logic             w_acc_write;
  logic [AW-1:0]    w_acc_idx;
  logic [CNT_W-1:0] w_cnt;

  assign w_req = memRead | memWrite;

  wait_counter u_wait_counter (
    .clk     (clk),
    .rst     (rst),
    .load    (w_start),
    .loadVal (WAIT_VAL),
    .en      (w_cnt_en),
    .count   (w_cnt),
    .last    (w_cnt_last)
  );

  // Next-state logic; a dropped request during WAIT abandons the access.
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_to_resp    = 1'b0;
    w_cnt_en     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_start = 1'b1;
          if (NO_WAIT) begin
            w_next_state = RESP;
            w_to_resp    = 1'b1;
          end else begin
            w_next_state = WAIT;
          end
        end else begin
          w_next_state = IDLE;
        end
      end
      WAIT: begin
        w_cnt_en = 1'b1;
        if (!w_req) begin
          w_next_state = IDLE;
        end else if (w_cnt_last || (w_cnt == {CNT_W{1'b0}})) begin
          w_next_state = RESP;
          w_to_resp    = 1'b1;
        end else begin
          w_next_state = WAIT;
        end
      end
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // With no wait states RESP is entered on the sampling edge, before the copies exist.
  always_comb begin
    if (r_state == IDLE) begin
      w_acc_idx   = address[AW+1:2];
      w_acc_bad   = req_bad(address, memRead, memWrite, AW);
      w_acc_write = memWrite & ~memRead;
    end else begin
      w_acc_idx   = r_idx;
      w_acc_bad   = r_bad;
      w_acc_write = r_write;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Request copies, captured once when a transaction starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx   <= {AW{1'b0}};
      r_wdata <= 32'd0;
      r_write <= 1'b0;
      r_bad   <= 1'b0;
    end else if (w_start) begin
      r_idx   <= w_acc_idx;
      r_wdata <= writeData;
      r_write <= w_acc_write;
      r_bad   <= w_acc_bad;
    end
  end

  // Response registers are non-zero only during the RESP cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
    end else if (w_to_resp) begin
      r_ready <= 1'b1;
      r_err   <= w_acc_bad;
      r_rdata <= (w_acc_bad | w_acc_write) ? 32'd0 : r_mem[w_acc_idx];
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
    end
  end

  assign w_commit = (r_state == RESP) & r_write & ~r_bad;

  // Storage is deliberately left out of reset; a store lands on the edge leaving RESP.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign readData = r_rdata;
  assign ready    = r_ready;
  assign err      = r_err;
  assign stall    = w_req & ~r_ready;

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 256, meaning storage size in 32-bit words (power of two, 16..4096).
REQ-002 Parameter WAIT_CYCLES, default 2, meaning wait states inserted before each access completes (0..15).
REQ-003 clk  input  1  meaning the single clock; all state updates on the rising edge.
REQ-004 rst  input  1  meaning asynchronous, active-low reset.
REQ-005 memRead  input  1  meaning load request from the core's MEM stage.
REQ-006 memWrite  input  1  meaning store request from the core's MEM stage.
REQ-007 address  input  32  meaning byte address of the access.
REQ-008 writeData  input  32  meaning store data.
REQ-009 readData  output  32  meaning load data, valid only in the cycle ready=1.
REQ-010 ready  output  1  meaning one-cycle completion pulse.
REQ-011 stall  output  1  meaning pipeline freeze request to the core's hazard logic.
REQ-012 err  output  1  meaning access rejected, qualified by ready.

Function
REQ-013 The block SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-014 IDLE: if memRead xor memWrite, the block SHALL latch address, writeData and the direction, load the wait counter with WAIT_CYCLES, and go to WAIT, or go directly to RESP if WAIT_CYCLES=0.
REQ-015 WAIT: the counter SHALL decrement once per cycle; at count 1 the FSM SHALL go to RESP.
REQ-016 RESP: ready=1 for exactly one cycle; a store SHALL commit at this edge; a load SHALL drive the latched word onto readData; the next state SHALL be IDLE.
REQ-017 Latency SHALL be WAIT_CYCLES+1 cycles from the request-sampling edge to the ready cycle.
REQ-018 The requester SHALL hold the request and its operands stable until ready; the block SHALL use only the latched copies.
REQ-019 If both memRead and memWrite drop during WAIT, the block SHALL abort to IDLE with no write and no ready pulse.
REQ-020 stall SHALL be the combinational value (memRead|memWrite) & ~ready.
REQ-021 Word index SHALL be address[log2(DEPTH)+1:2].
REQ-022 address[1:0]!=0, address>=4*DEPTH, or memRead&memWrite together SHALL complete through WAIT/RESP as normal, with err=1, readData=0 and no write during the ready cycle.
REQ-023 When not in a ready cycle, readData SHALL be 0 and err SHALL be 0.
REQ-024 A request still asserted in the IDLE cycle after RESP SHALL start a new transaction.
REQ-025 Storage SHALL have one read/write port, synchronous write only; no back-to-back bypass is needed because RESP is always followed by IDLE.

Reset
REQ-026 On rst low the block SHALL immediately force state to IDLE, the counter to 0, the latched registers to 0, and readData, ready and err to 0.
REQ-027 A reset during WAIT or RESP SHALL discard the transaction with no storage write.
REQ-028 Storage contents SHALL not be reset.

Structure
REQ-029 The shared package SHALL hold the state enum (IDLE/WAIT/RESP), the DEPTH and WAIT_CYCLES defaults, and the counter width of 4.
REQ-030 The down-counter SHALL be the sub-module wait_counter, with inputs load, loadVal and en, and outputs count and last.

Verification
REQ-031 Store: WAIT_CYCLES=2, memWrite, address=0x10, data=0xDEADBEEF -> stall high 3 cycles, ready on cycle 3, err=0; a following load of 0x10 returns 0xDEADBEEF.
REQ-032 WAIT_CYCLES=0: load of address 0x0 after a store of 0x12345678 -> ready in the cycle after sampling, readData=0x12345678, stall high exactly 1 cycle.
REQ-033 Errors: load at 0x13 -> ready with err=1, readData=0; store at 0x400 (DEPTH=256) -> err=1 and the word at index 0 is unchanged.
REQ-034 Abort: store to 0x20 with its request dropped mid-WAIT -> no ready; a later load of 0x20 returns the old value.
REQ-035 Reset mid-operation: rst low during WAIT of a store to 0x8 -> outputs 0 immediately, FSM in IDLE, word 0x8 unchanged after release.
